rr_mux_4_arbiter: RTL and testbench

Round-robin arbiter and output register wrapped around a 4-input, WIDTH-bit multiplexer. It shares one downstream valid/ready channel between four upstream requesters. Each cycle it picks one valid requester fairly, steers that requester's data through the 4:1 select path and captures it in a one-entry output register. It sits between independent producers and a single consumer in the combinational/sequential lab series.

---
 rtl/rr_mux_4_arbiter.sv | 71 +++++++
 tb/tb_rr_mux_4_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4_arbiter.sv
// Round-robin 4:1 arbiter/mux feeding a one-entry output register; 1-cycle accept-to-output latency.
// Backpressure: a held word (out_valid & ~out_ready) freezes all state and drops every in_ready.
module rr_mux_4_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data_0,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic [WIDTH-1:0] in_data_3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    logic [1:0]       ptr;
    logic [1:0]       grant;
    logic [3:0]       sel;
    logic             can_load;
    logic             any_valid;
    logic             load;
    logic [WIDTH-1:0] mux_data;

    assign can_load  = ~out_valid | out_ready;
    assign any_valid = |in_valid;
    assign load      = can_load & any_valid;

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        grant = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                grant = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        sel = 4'b0001 << grant;
    end

    // AND-OR select keeps unselected payloads (including X) off the output.
    assign mux_data = ({WIDTH{sel[0]}} & in_data_0)
                    | ({WIDTH{sel[1]}} & in_data_1)
                    | ({WIDTH{sel[2]}} & in_data_2)
                    | ({WIDTH{sel[3]}} & in_data_3);

    // Reset only masks the strobe here; it stays out of the flop data cone.
    assign in_ready = (load && !rst) ? sel : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (load) begin
            ptr       <= grant + 2'd1;
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= grant;
        end else if (can_load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_4_arbiter.sv
// Bench for rr_mux_4_arbiter: directed vector table, corner sequences, randomized model check.
module tb_rr_mux_4_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] d [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_mux_4_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_0 (d[0]),
        .in_data_1 (d[1]),
        .in_data_2 (d[2]),
        .in_data_3 (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [3:0]   v;
        logic         ordy;
        logic [W-1:0] d0, d1, d2, d3;
        logic [3:0]   e_rdy;
        logic         e_ov;
        logic [W-1:0] e_od;
        logic [1:0]   e_os;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic ordy,
                       input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3,
                       input logic [3:0] e_rdy, input logic e_ov,
                       input logic [W-1:0] e_od, input logic [1:0] e_os);
        vec_t r;
        r.v = v; r.ordy = ordy; r.d0 = a0; r.d1 = a1; r.d2 = a2; r.d3 = a3;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_od = e_od; r.e_os = e_os;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic [3:0] v, input logic ordy,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3);
        in_valid = v; out_ready = ordy;
        d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3;
    endtask

    // Reference model: priority order is the list ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    int           m_ptr;
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_os;
    int           wait_cnt [4];

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and in_ready suppression while reset is held
        rst = 1'b1;
        drive(4'hf, 1'b1, 4'h1, 4'h2, 4'h4, 4'h8);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Rotation, alternation, backpressure and idle/hold behaviour
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b0001, 1, 4'h1, 0);
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b0010, 1, 4'h2, 1);
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b0100, 1, 4'h4, 2);
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b1000, 1, 4'h8, 3);
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b0001, 1, 4'h1, 0);
        add(4'b1010, 1, 4'h0, 4'h7, 4'h0, 4'h3, 4'b0010, 1, 4'h7, 1);
        add(4'b1010, 1, 4'h0, 4'h7, 4'h0, 4'h3, 4'b1000, 1, 4'h3, 3);
        add(4'b1010, 1, 4'h0, 4'h7, 4'h0, 4'h3, 4'b0010, 1, 4'h7, 1);
        add(4'b1010, 1, 4'h0, 4'h7, 4'h0, 4'h3, 4'b1000, 1, 4'h3, 3);
        add(4'b0100, 1, 4'h0, 4'h0, 4'h5, 4'h0, 4'b0100, 1, 4'h5, 2);
        for (int i = 0; i < 4; i++)
            add(4'hf, 0, 4'h1, 4'h2, 4'h4, 4'h8, 4'b0000, 1, 4'h5, 2);
        add(4'hf, 1, 4'h1, 4'h2, 4'h4, 4'h8, 4'b1000, 1, 4'h8, 3);
        add(4'b0001, 1, 4'ha, 4'h0, 4'h0, 4'h0, 4'b0001, 1, 4'ha, 0);
        add(4'b0000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 4'ha, 0);
        add(4'b0100, 0, 4'h0, 4'h0, 4'h6, 4'h0, 4'b0100, 1, 4'h6, 2);
        add(4'b0000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1, 4'h6, 2);
        add(4'b0000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 4'h6, 2);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].ordy, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            check($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
            check($sformatf("vec%0d_out_src", i), out_src, tbl[i].e_os);
        end

        // Pointer wrap: last grant 3, then only requester 0
        drive(4'b1000, 1, 4'h0, 4'h0, 4'h0, 4'h9);
        @(posedge clk); #1;
        check("wrap_src3", out_src, 3);
        drive(4'b0001, 1, 4'ha, 4'h0, 4'h0, 4'h0);
        #1;
        check("wrap_in_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        check("wrap_out_data", out_data, 4'ha);
        check("wrap_out_src", out_src, 0);
        check("wrap_ptr", dut.ptr, 1);

        // X isolation on an unselected requester
        drive(4'b0001, 1, 4'h7, 4'h0, 4'h0, 4'h0);
        d[3] = 'x;
        @(posedge clk); #1;
        check("xiso_out_data", out_data, 4'h7);
        check("xiso_no_x", $isunknown(out_data), 0);

        // Reset mid-operation with out_valid=1 and ptr=2
        drive(4'b0010, 1, 4'h0, 4'hb, 4'h0, 4'h0);
        @(posedge clk); #1;
        drive(4'hf, 0, 4'h1, 4'h2, 4'h4, 4'h8);
        check("mid_pre_ptr", dut.ptr, 2);
        check("mid_pre_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_src", out_src, 0);
        check("mid_rst_ptr", dut.ptr, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        check("post_rst_src", out_src, 0);
        check("post_rst_data", out_data, 4'h1);

        // Randomized run against the reference model
        rst = 1'b1;
        drive(4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  g;
            bit  can;
            logic [3:0] exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_valid[i] = 1'b1;
                    d[i] = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            can = !m_ov || out_ready;
            g = pick(in_valid, m_ptr);
            exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
            check("rand_in_ready", in_ready, exp_rdy);
            @(posedge clk);
            if (can && g >= 0) begin
                m_od = d[g]; m_os = g; m_ov = 1; m_ptr = (g + 1) % 4;
                for (int i = 0; i < 4; i++) begin
                    if (i != g && in_valid[i]) begin
                        wait_cnt[i]++;
                        check("rand_fairness", wait_cnt[i] <= 3, 1);
                    end
                end
                wait_cnt[g] = 0;
            end else if (can) begin
                m_ov = 0;
            end
            #1;
            check("rand_out_valid", out_valid, m_ov);
            check("rand_out_data", out_data, m_od);
            check("rand_out_src", out_src, m_os);
            if (can && g >= 0) in_valid[g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
